// File: rtl/add_sub_checker.sv
// On-chip response checker for an add/sub datapath: recomputes {cout,s} for each
// accepted vector and keeps run statistics plus a capture of the first mismatch.
module add_sub_checker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_m,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_s,
  input  logic             in_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH:0]   first_err_exp,
  output logic [1:0]       state_dbg
);

  // Handshake: a vector transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on registered state, never on in_valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic             pipe_vld_q, pipe_vld_d;
  logic             pipe_m_q, pipe_m_d;
  logic [WIDTH-1:0] pipe_a_q, pipe_a_d;
  logic [WIDTH-1:0] pipe_b_q, pipe_b_d;
  logic [WIDTH-1:0] pipe_s_q, pipe_s_d;
  logic             pipe_c_q, pipe_c_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             fe_vld_q, fe_vld_d;
  logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
  logic [WIDTH:0]   fe_exp_q, fe_exp_d;

  logic             accept;
  logic             start_ok;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   exp_res;
  logic             mismatch;

  assign in_ready = (state_q == S_RUN) && (acc_q < num_q);
  assign accept   = in_valid && in_ready;
  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Subtract as a + ~b + 1 so the carry-out directly means "no borrow".
  assign a_ext    = {1'b0, pipe_a_q};
  assign b_ext    = pipe_m_q ? {1'b0, ~pipe_b_q} : {1'b0, pipe_b_q};
  assign exp_res  = a_ext + b_ext + {{WIDTH{1'b0}}, pipe_m_q};
  assign mismatch = pipe_vld_q && ({pipe_c_q, pipe_s_q} != exp_res);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (acc_q == num_q) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    num_d      = num_q;
    acc_d      = acc_q;
    pipe_vld_d = accept;
    pipe_m_d   = pipe_m_q;
    pipe_a_d   = pipe_a_q;
    pipe_b_d   = pipe_b_q;
    pipe_s_d   = pipe_s_q;
    pipe_c_d   = pipe_c_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    fe_vld_d   = fe_vld_q;
    fe_idx_d   = fe_idx_q;
    fe_exp_d   = fe_exp_q;
    if (accept) begin
      acc_d    = acc_q + CNT_W'(1);
      pipe_m_d = in_m;
      pipe_a_d = in_a;
      pipe_b_d = in_b;
      pipe_s_d = in_s;
      pipe_c_d = in_cout;
    end
    if (pipe_vld_q) begin
      vec_cnt_d = vec_cnt_q + CNT_W'(1);
      if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        if (!fe_vld_q) begin
          fe_vld_d = 1'b1;
          fe_idx_d = vec_cnt_q;
          fe_exp_d = exp_res;
        end
      end
    end
    if (start_ok) begin
      num_d      = num_vec;
      acc_d      = '0;
      pipe_vld_d = 1'b0;
      vec_cnt_d  = '0;
      err_cnt_d  = '0;
      fe_vld_d   = 1'b0;
      fe_idx_d   = '0;
      fe_exp_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      acc_q      <= '0;
      pipe_vld_q <= 1'b0;
      pipe_m_q   <= 1'b0;
      pipe_a_q   <= '0;
      pipe_b_q   <= '0;
      pipe_s_q   <= '0;
      pipe_c_q   <= 1'b0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      fe_vld_q   <= 1'b0;
      fe_idx_q   <= '0;
      fe_exp_q   <= '0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      acc_q      <= acc_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_m_q   <= pipe_m_d;
      pipe_a_q   <= pipe_a_d;
      pipe_b_q   <= pipe_b_d;
      pipe_s_q   <= pipe_s_d;
      pipe_c_q   <= pipe_c_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      fe_vld_q   <= fe_vld_d;
      fe_idx_q   <= fe_idx_d;
      fe_exp_q   <= fe_exp_d;
    end
  end

  assign busy            = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done            = (state_q == S_DONE);
  assign pass            = done && (err_cnt_q == '0);
  assign vec_cnt         = vec_cnt_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_valid = fe_vld_q;
  assign first_err_idx   = fe_idx_q;
  assign first_err_exp   = fe_exp_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_add_sub_checker.sv
// Bench for add_sub_checker: reference model of a check run, per-cycle compare,
// directed scenarios with literal expectations, and randomized runs.
module tb_add_sub_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] num_vec = '0;
  logic       in_valid = 1'b0;
  logic       in_m = 1'b0;
  logic [3:0] in_a = '0, in_b = '0, in_s = '0;
  logic       in_cout = 1'b0;
  logic       in_ready, busy, done, pass, first_err_valid;
  logic [7:0] vec_cnt, err_cnt, first_err_idx;
  logic [4:0] first_err_exp;
  logic [1:0] state_dbg;

  logic       start2 = 1'b0;
  logic [1:0] num_vec2 = '0;
  logic       in_ready2, busy2, done2, pass2, first_err_valid2;
  logic [1:0] vec_cnt2, err_cnt2, first_err_idx2;
  logic [4:0] first_err_exp2;
  logic [1:0] state_dbg2;

  add_sub_checker #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_a(in_a),
    .in_b(in_b), .in_s(in_s), .in_cout(in_cout), .busy(busy), .done(done),
    .pass(pass), .vec_cnt(vec_cnt), .err_cnt(err_cnt),
    .first_err_valid(first_err_valid), .first_err_idx(first_err_idx),
    .first_err_exp(first_err_exp), .state_dbg(state_dbg)
  );

  add_sub_checker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .num_vec(num_vec2),
    .in_valid(in_valid), .in_ready(in_ready2), .in_m(in_m), .in_a(in_a),
    .in_b(in_b), .in_s(in_s), .in_cout(in_cout), .busy(busy2), .done(done2),
    .pass(pass2), .vec_cnt(vec_cnt2), .err_cnt(err_cnt2),
    .first_err_valid(first_err_valid2), .first_err_idx(first_err_idx2),
    .first_err_exp(first_err_exp2), .state_dbg(state_dbg2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected {cout,s}: sum, or difference offset by 16 so bit 4 reads "no borrow".
  function automatic logic [4:0] expect_of(input logic m, input logic [3:0] a, input logic [3:0] b);
    int r;
    r = m ? (int'(a) + 16 - int'(b)) : (int'(a) + int'(b));
    return 5'(r);
  endfunction

  // Reference model of a run, tracking DUT instance 'dut' (CNT_W=8).
  int         m_running = 0, m_done = 0, m_acc = 0, m_num = 0, m_tail = 0;
  int         m_vec = 0, m_err = 0, m_fev = 0, m_fei = 0;
  logic [4:0] m_fee = '0;
  logic [5:0] pend[$];
  bit         checking = 0;

  always @(posedge clk or posedge rst) begin : model
    logic [5:0] p;
    logic [4:0] e;
    if (rst) begin
      m_running = 0; m_done = 0; m_acc = 0; m_num = 0; m_tail = 0;
      m_vec = 0; m_err = 0; m_fev = 0; m_fei = 0; m_fee = '0;
      pend.delete();
    end else begin
      if (pend.size() > 0) begin
        p = pend.pop_front();
        m_vec++;
        if (p[5]) begin
          if (m_err < 255) m_err++;
          if (m_fev == 0) begin m_fev = 1; m_fei = m_vec - 1; m_fee = p[4:0]; end
        end
      end
      if (m_running != 0) begin
        if (m_acc == m_num) begin
          m_tail++;
          if (m_tail == 2) begin m_running = 0; m_done = 1; end
        end else if (in_valid) begin
          e = expect_of(in_m, in_a, in_b);
          pend.push_back({({in_cout, in_s} != e), e});
          m_acc++;
        end
      end else if (start) begin
        m_running = 1; m_done = 0; m_num = int'(num_vec); m_acc = 0; m_tail = 0;
        m_vec = 0; m_err = 0; m_fev = 0; m_fei = 0; m_fee = '0;
        pend.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("in_ready", 32'(in_ready), 32'(m_running != 0 && m_acc < m_num));
      chk("busy", 32'(busy), 32'(m_running != 0));
      chk("done", 32'(done), 32'(m_done != 0));
      chk("pass", 32'(pass), 32'(m_done != 0 && m_err == 0));
      chk("vec_cnt", 32'(vec_cnt), 32'(m_vec));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      chk("first_err_valid", 32'(first_err_valid), 32'(m_fev));
      chk("first_err_idx", 32'(first_err_idx), 32'(m_fei));
      chk("first_err_exp", 32'(first_err_exp), 32'(m_fee));
    end
  end

  // Driver side: vectors packed {m,a,b,s,cout}.
  logic [13:0] vq[$];

  function automatic logic [13:0] mk(input logic m, input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] s, input logic c);
    return {m, a, b, s, c};
  endfunction

  function automatic logic [13:0] rnd_vec(input int bad_pct);
    logic m; logic [3:0] a, b; logic [4:0] r;
    m = 1'($urandom_range(0, 1));
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    r = expect_of(m, a, b);
    if (int'($urandom_range(0, 99)) < bad_pct) r = r ^ 5'($urandom_range(1, 31));
    return mk(m, a, b, r[3:0], r[4]);
  endfunction

  task automatic do_start(input int n, input bit use2);
    @(posedge clk); #1;
    if (use2) begin start2 = 1'b1; num_vec2 = 2'(n); end
    else begin start = 1'b1; num_vec = 8'(n); end
    @(posedge clk); #1;
    start = 1'b0; start2 = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 every other cycle, 2 random gaps plus stray start pulses
  task automatic feed(input int gap, input bit use2);
    int  guard;
    bit  acc;
    guard = 0;
    while (vq.size() > 0 && guard < 500) begin
      {in_m, in_a, in_b, in_s, in_cout} = vq[0];
      if (gap == 0) in_valid = 1'b1;
      else if (gap == 1) in_valid = (guard % 2 == 0);
      else in_valid = ($urandom_range(0, 2) != 0);
      if (gap == 2) begin
        start = ($urandom_range(0, 7) == 0);
        num_vec = 8'($urandom_range(0, 255));
      end
      acc = in_valid && (use2 ? in_ready2 : in_ready);
      @(posedge clk); #1;
      if (acc) void'(vq.pop_front());
      guard++;
    end
    in_valid = 1'b0;
    if (gap == 2) start = 1'b0;
    if (vq.size() > 0) begin
      n_cmp++; n_err++;
      $display("FAIL feed_timeout: %0d vectors left, want 0", vq.size());
      vq.delete();
    end
  endtask

  task automatic wait_done(input bit use2, output int cyc, output bit saw_ready);
    cyc = 0;
    saw_ready = 0;
    while (!(use2 ? done2 : done) && cyc < 100) begin
      if (use2 ? in_ready2 : in_ready) saw_ready = 1;
      @(posedge clk); #1;
      cyc++;
    end
    if (!(use2 ? done2 : done)) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: done=0 after %0d cycles, want 1", cyc);
    end
  endtask

  initial begin
    int  cyc, n;
    bit  sr;

    #2 rst = 1'b1;
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_vec_cnt", 32'(vec_cnt), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    chk("rst_fe_valid", 32'(first_err_valid), 0);
    chk("rst_fe_exp", 32'(first_err_exp), 0);
    @(posedge clk); #1 rst = 1'b0;
    checking = 1;

    // Four correct vectors back-to-back.
    vq.push_back(mk(0, 4'b0010, 4'b0101, 4'b0111, 0));
    vq.push_back(mk(1, 4'b0100, 4'b0010, 4'b0010, 1));
    vq.push_back(mk(1, 4'b0010, 4'b0111, 4'b1011, 0));
    vq.push_back(mk(0, 4'b1100, 4'b1101, 4'b1001, 1));
    do_start(4, 0);
    feed(0, 0);
    wait_done(0, cyc, sr);
    chk("t1_done_latency", 32'(cyc), 2);
    chk("t1_vec_cnt", 32'(vec_cnt), 4);
    chk("t1_err_cnt", 32'(err_cnt), 0);
    chk("t1_pass", 32'(pass), 1);

    // Two mismatches; the first one is captured.
    vq.push_back(mk(0, 4'b0011, 4'b0001, 4'b0100, 0));
    vq.push_back(mk(1, 4'b1111, 4'b1111, 4'b0001, 1));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0011, 0));
    do_start(3, 0);
    feed(0, 0);
    wait_done(0, cyc, sr);
    chk("t2_err_cnt", 32'(err_cnt), 2);
    chk("t2_fe_idx", 32'(first_err_idx), 1);
    chk("t2_fe_exp", 32'(first_err_exp), 32'h10);
    chk("t2_pass", 32'(pass), 0);

    // Empty run.
    do_start(0, 0);
    wait_done(0, cyc, sr);
    chk("t3_done_latency", 32'(cyc), 2);
    chk("t3_saw_ready", 32'(sr), 0);
    chk("t3_pass", 32'(pass), 1);
    chk("t3_vec_cnt", 32'(vec_cnt), 0);

    // Gapped valid, then valid held after the last accept.
    vq.push_back(rnd_vec(0));
    vq.push_back(rnd_vec(0));
    do_start(2, 0);
    feed(1, 0);
    in_valid = 1'b1;
    chk("t4_ready_after_last", 32'(in_ready), 0);
    @(posedge clk); #1;
    chk("t4_ready_drain", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_vec_cnt", 32'(vec_cnt), 2);
    chk("t4_done", 32'(done), 1);

    // Asynchronous reset mid-run.
    vq.push_back(rnd_vec(100));
    do_start(5, 0);
    feed(0, 0);
    #3 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    chk("t5_vec_cnt", 32'(vec_cnt), 0);
    chk("t5_err_cnt", 32'(err_cnt), 0);
    chk("t5_fe_valid", 32'(first_err_valid), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) vq.push_back(rnd_vec(50));
    do_start(3, 0);
    feed(0, 0);
    wait_done(0, cyc, sr);
    chk("t5_rerun_vec_cnt", 32'(vec_cnt), 3);

    // Narrow counters: three corrupted vectors, start pulses held during the run.
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0000, 0));
    do_start(3, 1);
    feed(0, 1);
    start2 = 1'b1; num_vec2 = 2'd1;
    vq.push_back(mk(1, 4'b0101, 4'b0011, 4'b0010, 0));
    vq.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, 0));
    feed(0, 1);
    start2 = 1'b0;
    wait_done(1, cyc, sr);
    chk("t6_vec_cnt", 32'(vec_cnt2), 3);
    chk("t6_err_cnt", 32'(err_cnt2), 3);
    chk("t6_fe_idx", 32'(first_err_idx2), 0);
    chk("t6_fe_exp", 32'(first_err_exp2), 32'h02);
    chk("t6_pass", 32'(pass2), 0);

    // Randomized runs with gaps, corruption and stray starts.
    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) vq.push_back(rnd_vec(25));
      do_start(n, 0);
      feed(2, 0);
      wait_done(0, cyc, sr);
      chk("rnd_vec_cnt", 32'(vec_cnt), 32'(n));
    end

    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
